conv_pool_engine: RTL and testbench
===================================

// Module: conv_pool_engine
// PURPOSE
//  Parametrised successor of the fixed 3x3 conv block: IMG_W x IMG_W image, run-time 3x3 kernel/bias,
//  zero padding, optional ReLU, then 2x2/stride-2 pooling (max or average) into layer-1 memory.
//  Sits between the image ROM (iaddr/idata) and the shared layer memory (csel 0 = L0, 1 = L1).
// PARAMETERS
//  IMG_W   64  image side, power of two >= 4
//  DATA_W  13  signed pixel/result width, FRAC_W fractional bits
//  W_W     13  signed kernel/bias width, FRAC_W fractional bits
//  FRAC_W  4   fractional bits of pixels, weights and bias
//  (localparam ADDR_W = 2*$clog2(IMG_W); ACC_W = DATA_W+W_W+4)
// PORTS
//  clk       in   1            rising-edge clock
//  reset     in   1            synchronous, active-high
//  ready     in   1            start request, sampled only in IDLE
//  busy      out  1            high from start until last L1 write completes
//  pool_mode in   1            0 = max, 1 = average; latched at start
//  relu_en   in   1            1 = clamp negative conv results to 0; latched at start
//  kernel    in   9*W_W        taps K0..K8 raster order, K0 in LSBs; latched at start
//  bias      in   W_W          conv bias; latched at start
//  iaddr     out  ADDR_W       image read address (row*IMG_W+col)
//  idata     in   DATA_W       image data for iaddr, valid at next rising edge
//  cwr       out  1            layer memory write strobe
//  caddr_wr  out  ADDR_W       write address
//  cdata_wr  out  DATA_W       write data
//  crd       out  1            layer memory read strobe
//  caddr_rd  out  ADDR_W       read address
//  cdata_rd  in   DATA_W       read data for caddr_rd, valid at next rising edge
//  csel      out  1            0 = layer 0, 1 = layer 1
// BEHAVIOUR
//  - Reset: busy=0, cwr=0, crd=0, csel=0, iaddr/caddr_wr/caddr_rd/cdata_wr=0, state IDLE, counters 0.
//    Reset mid-operation aborts immediately; no further writes; a new ready restarts from pixel 0.
//  - Start: IDLE && ready -> busy=1 at next edge, config latched on same edge. ready ignored while busy.
//  - FSM: IDLE -> CONV_RD(9 cyc) -> CONV_WR(1) -> ...all IMG_W^2 pixels raster... -> POOL_RD(4) -> POOL_WR(1)
//    -> ...all (IMG_W/2)^2 outputs... -> IDLE. busy falls at edge ending final POOL_WR.
//  - Busy length exactly IMG_W^2*10 + (IMG_W/2)^2*5 cycles; first cwr in busy cycle 10.
//  - CONV_RD tap t=0..8, offset (dr,dc)=(t/3-1, t%3-1); iaddr issued in cycle t, idata accumulated
//    at edge ending cycle t. Out-of-image tap: still one cycle, contributes 0, iaddr don't-care.
//  - Arithmetic: acc = (bias<<<FRAC_W) + sum(idata*K_t), ACC_W signed; res = (acc + 2^(FRAC_W-1)) >>> FRAC_W;
//    saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; then ReLU if relu_en.
//  - CONV_WR: cwr=1, csel=0, caddr_wr=row*IMG_W+col, cdata_wr=res. crd=0.
//  - POOL_RD: crd=1, csel=0, caddr_rd raster over 2x2 window (r,c),(r,c+1),(r+1,c),(r+1,c+1).
//  - POOL_WR: cwr=1, csel=1, caddr_wr=(r/2)*(IMG_W/2)+c/2; max = signed max; avg = (sum4+2)>>>2, sum4 DATA_W+2 bits.
//  - cwr and crd never high in the same cycle; outside active states both 0.
// STRUCTURE
//  - conv_pkg: state enum, tap offset table, sat_round function, ADDR_W/ACC_W helpers.
//  - One sub-module conv_mac_sat: accumulate/clear, round, saturate, ReLU; top keeps FSM, counters, pooling.
// TESTING
//  1. IMG_W=4, idata=16 (1.0) everywhere, K=16 all, bias 0, relu 1, max -> L0 corners 64, edges 96,
//     interior 144; L1 all 144.
//  2. Same, pool_mode=1 -> L1[0]=(64+96+96+144+2)>>>2=100, all four L1 entries 100.
//  3. idata=0x0FFF, K=16 all -> L0 all 0x0FFF (saturated); K=-16, relu 0 -> 0x1000; relu 1 -> 0.
//  4. Only K4=8 (0.5): idata=1 -> L0=1 (round up); idata=-1 -> L0=0; bias=16, idata=0 -> L0=16.
//  5. IMG_W=4: busy high exactly 180 cycles; reset at pixel 5 -> next cycle busy=0, cwr=0, crd=0;
//     re-start reproduces test-1 results exactly.
//  6. Default IMG_W=64, golden kernel/bias, relu 1, max -> L0 4096 and L1 1024 words match golden files.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv/pool engine: FSM states, tap offsets and
// the round-then-saturate step applied to every convolution result.
package conv_pkg;

    typedef enum logic [2:0] {StIdle, StConvRd, StConvWr, StPoolRd, StPoolWr} state_t;

    function automatic int unsigned addr_w(input int unsigned img_w);
        return 2 * $clog2(img_w);
    endfunction

    function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned w_w);
        return data_w + w_w + 4;
    endfunction

    // Tap t sits at (t/3-1, t%3-1); offsets are 2-bit two's complement.
    function automatic logic [1:0] tap_dr(input logic [3:0] t);
        if (t < 4'd3)      return 2'b11;
        else if (t < 4'd6) return 2'b00;
        else               return 2'b01;
    endfunction

    function automatic logic [1:0] tap_dc(input logic [3:0] t);
        case (t)
            4'd0, 4'd3, 4'd6: return 2'b11;
            4'd1, 4'd4, 4'd7: return 2'b00;
            default:          return 2'b01;
        endcase
    endfunction

    function automatic longint sat_round(input longint acc, input int unsigned frac_w,
                                         input int unsigned data_w);
        longint r;
        longint hi;
        longint lo;
        r  = (acc + (longint'(1) <<< (frac_w - 1))) >>> frac_w;
        hi = (longint'(1) <<< (data_w - 1)) - longint'(1);
        lo = -(longint'(1) <<< (data_w - 1));
        if (r > hi)      r = hi;
        else if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/conv_mac_sat.sv
// Multiply-accumulate for one 3x3 window, seeded with the bias on the first tap,
// followed by rounding, saturation and optional ReLU.
module conv_mac_sat
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 13,
    parameter int unsigned W_W    = 13,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc_en,
    input  logic              first,
    input  logic              tap_valid,
    input  logic              relu_en,
    input  logic [DATA_W-1:0] pix,
    input  logic [W_W-1:0]    weight,
    input  logic [W_W-1:0]    bias,
    output logic [DATA_W-1:0] res
);
    localparam int unsigned ACC_W = acc_w(DATA_W, W_W);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] pix_ext, w_ext, prod, base;

    always_comb begin
        pix_ext = {{(ACC_W - DATA_W){pix[DATA_W-1]}}, pix};
        w_ext   = {{(ACC_W - W_W){weight[W_W-1]}}, weight};
        prod    = tap_valid ? pix_ext * w_ext : '0;
        base    = first ? {{(ACC_W - W_W - FRAC_W){bias[W_W-1]}}, bias, {FRAC_W{1'b0}}} : acc_q;
        acc_d   = acc_en ? base + prod : acc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    always_comb begin
        res = DATA_W'(sat_round(longint'(acc_q), FRAC_W, DATA_W));
        if (relu_en && res[DATA_W-1]) res = '0;
    end

endmodule

// File: rtl/conv_pool_engine.sv
// 3x3 conv with zero padding into layer 0, then 2x2/stride-2 max/avg pooling into layer 1.
// Image ROM and layer memory both return data combinationally by the next rising edge.
module conv_pool_engine
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned DATA_W = 13,
    parameter int unsigned W_W    = 13,
    parameter int unsigned FRAC_W = 4,
    localparam int unsigned ADDR_W = addr_w(IMG_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    output logic               busy,
    input  logic               pool_mode,
    input  logic               relu_en,
    input  logic [9*W_W-1:0]   kernel,
    input  logic [W_W-1:0]     bias,
    output logic [ADDR_W-1:0]  iaddr,
    input  logic [DATA_W-1:0]  idata,
    output logic               cwr,
    output logic [ADDR_W-1:0]  caddr_wr,
    output logic [DATA_W-1:0]  cdata_wr,
    output logic               crd,
    output logic [ADDR_W-1:0]  caddr_rd,
    input  logic [DATA_W-1:0]  cdata_rd,
    output logic               csel
);
    localparam int unsigned LOG_W = ADDR_W / 2;
    localparam int unsigned PW    = LOG_W - 1;

    state_t               state_q, state_d;
    logic [LOG_W-1:0]     row_q, row_d, col_q, col_d;
    logic [3:0]           tap_q, tap_d;
    logic [PW-1:0]        prow_q, prow_d, pcol_q, pcol_d;
    logic [1:0]           quad_q, quad_d;
    logic                 pool_mode_q, pool_mode_d, relu_q, relu_d;
    logic [9*W_W-1:0]     kernel_q, kernel_d;
    logic [W_W-1:0]       bias_q, bias_d;
    logic signed [DATA_W-1:0] max_q, max_d;
    logic signed [DATA_W+1:0] sum_q, sum_d, rd_ext;
    logic [1:0]           dr, dc;
    logic [LOG_W+1:0]     tr, tc;
    logic                 tap_valid;
    logic [DATA_W-1:0]    conv_res;

    // Top two bits of the offset row/col are zero only when the tap lies inside the image.
    always_comb begin
        dr        = tap_dr(tap_q);
        dc        = tap_dc(tap_q);
        tr        = {2'b00, row_q} + {{LOG_W{dr[1]}}, dr};
        tc        = {2'b00, col_q} + {{LOG_W{dc[1]}}, dc};
        tap_valid = (tr[LOG_W+1:LOG_W] == 2'b00) && (tc[LOG_W+1:LOG_W] == 2'b00);
        rd_ext    = {{2{cdata_rd[DATA_W-1]}}, cdata_rd};
    end

    conv_mac_sat #(
        .DATA_W (DATA_W),
        .W_W    (W_W),
        .FRAC_W (FRAC_W)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .acc_en    (state_q == StConvRd),
        .first     (tap_q == 4'd0),
        .tap_valid (tap_valid),
        .relu_en   (relu_q),
        .pix       (idata),
        .weight    (kernel_q[tap_q*W_W +: W_W]),
        .bias      (bias_q),
        .res       (conv_res)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        tap_d       = tap_q;
        prow_d      = prow_q;
        pcol_d      = pcol_q;
        quad_d      = quad_q;
        pool_mode_d = pool_mode_q;
        relu_d      = relu_q;
        kernel_d    = kernel_q;
        bias_d      = bias_q;
        max_d       = max_q;
        sum_d       = sum_q;
        busy        = 1'b0;
        iaddr       = '0;
        cwr         = 1'b0;
        caddr_wr    = '0;
        cdata_wr    = '0;
        crd         = 1'b0;
        caddr_rd    = '0;
        csel        = 1'b0;
        case (state_q)
            StIdle: begin
                if (ready) begin
                    state_d     = StConvRd;
                    pool_mode_d = pool_mode;
                    relu_d      = relu_en;
                    kernel_d    = kernel;
                    bias_d      = bias;
                    row_d       = '0;
                    col_d       = '0;
                    tap_d       = '0;
                    prow_d      = '0;
                    pcol_d      = '0;
                    quad_d      = '0;
                end
            end
            StConvRd: begin
                busy  = 1'b1;
                iaddr = {tr[LOG_W-1:0], tc[LOG_W-1:0]};
                tap_d = tap_q + 4'd1;
                if (tap_q == 4'd8) begin
                    tap_d   = '0;
                    state_d = StConvWr;
                end
            end
            StConvWr: begin
                busy     = 1'b1;
                cwr      = 1'b1;
                caddr_wr = {row_q, col_q};
                cdata_wr = conv_res;
                col_d    = col_q + 1'b1;
                state_d  = StConvRd;
                if (&col_q) begin
                    row_d = row_q + 1'b1;
                    if (&row_q) state_d = StPoolRd;
                end
            end
            StPoolRd: begin
                busy     = 1'b1;
                crd      = 1'b1;
                caddr_rd = {prow_q, quad_q[1], pcol_q, quad_q[0]};
                quad_d   = quad_q + 2'd1;
                if (quad_q == 2'd0) begin
                    max_d = cdata_rd;
                    sum_d = rd_ext;
                end else begin
                    max_d = ($signed(cdata_rd) > max_q) ? cdata_rd : max_q;
                    sum_d = sum_q + rd_ext;
                end
                if (&quad_q) state_d = StPoolWr;
            end
            StPoolWr: begin
                busy     = 1'b1;
                cwr      = 1'b1;
                csel     = 1'b1;
                caddr_wr = {2'b00, prow_q, pcol_q};
                cdata_wr = pool_mode_q ? DATA_W'((sum_q + 2) >>> 2) : max_q;
                pcol_d   = pcol_q + 1'b1;
                state_d  = StPoolRd;
                if (&pcol_q) begin
                    prow_d = prow_q + 1'b1;
                    if (&prow_q) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            tap_q       <= '0;
            prow_q      <= '0;
            pcol_q      <= '0;
            quad_q      <= '0;
            pool_mode_q <= 1'b0;
            relu_q      <= 1'b0;
            kernel_q    <= '0;
            bias_q      <= '0;
            max_q       <= '0;
            sum_q       <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            tap_q       <= tap_d;
            prow_q      <= prow_d;
            pcol_q      <= pcol_d;
            quad_q      <= quad_d;
            pool_mode_q <= pool_mode_d;
            relu_q      <= relu_d;
            kernel_q    <= kernel_d;
            bias_q      <= bias_d;
            max_q       <= max_d;
            sum_q       <= sum_d;
        end
    end

endmodule

// File: tb/tb_conv_pool_engine.sv
// Scoreboard bench for conv_pool_engine at IMG_W=4: directed cases plus random images/kernels,
// expected writes produced by a plain-arithmetic convolution and pooling model.
module tb_conv_pool_engine;

    localparam int IMG_W    = 4;
    localparam int DATA_W   = 13;
    localparam int W_W      = 13;
    localparam int FRAC_W   = 4;
    localparam int ADDR_W   = 2 * $clog2(IMG_W);
    localparam int NPIX     = IMG_W * IMG_W;
    localparam int HALF     = IMG_W / 2;
    localparam int NOUT     = HALF * HALF;
    localparam int BUSY_LEN = NPIX * 10 + NOUT * 5;
    localparam int RND      = 1 << (FRAC_W - 1);
    localparam int VMAX     = (1 << (DATA_W - 1)) - 1;
    localparam int VMIN     = -(1 << (DATA_W - 1));

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ready = 1'b0;
    logic pool_mode = 1'b0;
    logic relu_en = 1'b0;
    logic [9*W_W-1:0] kernel = '0;
    logic [W_W-1:0] bias = '0;
    logic busy, cwr, crd, csel;
    logic [ADDR_W-1:0] iaddr, caddr_wr, caddr_rd;
    logic signed [DATA_W-1:0] idata, cdata_wr, cdata_rd;

    logic signed [DATA_W-1:0] img [NPIX];
    logic signed [DATA_W-1:0] l0 [NPIX];
    logic signed [DATA_W-1:0] l1 [NPIX];

    typedef struct {
        int sel;
        int addr;
        int data;
    } exp_t;
    exp_t sb[$];

    int img_v [NPIX];
    int k_v [9];
    int bias_v;
    int exp_l0 [NPIX];
    int n_checks = 0;
    int n_fail = 0;
    int wr_count = 0;

    conv_pool_engine #(
        .IMG_W  (IMG_W),
        .DATA_W (DATA_W),
        .W_W    (W_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ready     (ready),
        .busy      (busy),
        .pool_mode (pool_mode),
        .relu_en   (relu_en),
        .kernel    (kernel),
        .bias      (bias),
        .iaddr     (iaddr),
        .idata     (idata),
        .cwr       (cwr),
        .caddr_wr  (caddr_wr),
        .cdata_wr  (cdata_wr),
        .crd       (crd),
        .caddr_rd  (caddr_rd),
        .cdata_rd  (cdata_rd),
        .csel      (csel)
    );

    always #5 clk = ~clk;

    assign idata    = img[iaddr];
    assign cdata_rd = l0[caddr_rd];

    always @(posedge clk) begin
        if (cwr) begin
            if (csel) l1[caddr_wr] <= cdata_wr;
            else      l0[caddr_wr] <= cdata_wr;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy) check("cwr_crd_exclusive", longint'(cwr & crd), 0);
            if (crd) check("rd_sel", longint'(csel), 0);
            if (cwr) begin
                wr_count++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: sel %0d addr %0d data %0d, none expected",
                             csel, caddr_wr, cdata_wr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wr_sel", longint'(csel), e.sel);
                    check("wr_addr", longint'(caddr_wr), e.addr);
                    check("wr_data", longint'(cdata_wr), e.data);
                end
            end
        end
    end

    function automatic int clamp(input longint v);
        if (v > VMAX) return VMAX;
        if (v < VMIN) return VMIN;
        return int'(v);
    endfunction

    task automatic build_expected();
        for (int r = 0; r < IMG_W; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                longint acc;
                int v;
                acc = longint'(bias_v) * (1 << FRAC_W);
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (r + dr >= 0 && r + dr < IMG_W && c + dc >= 0 && c + dc < IMG_W)
                            acc += longint'(img_v[(r + dr) * IMG_W + c + dc]) *
                                   k_v[(dr + 1) * 3 + dc + 1];
                    end
                end
                v = clamp((acc + RND) >>> FRAC_W);
                if (relu_en && v < 0) v = 0;
                exp_l0[r * IMG_W + c] = v;
                sb.push_back('{sel: 0, addr: r * IMG_W + c, data: v});
            end
        end
        for (int r = 0; r < HALF; r++) begin
            for (int c = 0; c < HALF; c++) begin
                int w [4];
                int v;
                w[0] = exp_l0[(2 * r) * IMG_W + 2 * c];
                w[1] = exp_l0[(2 * r) * IMG_W + 2 * c + 1];
                w[2] = exp_l0[(2 * r + 1) * IMG_W + 2 * c];
                w[3] = exp_l0[(2 * r + 1) * IMG_W + 2 * c + 1];
                if (pool_mode) begin
                    v = (w[0] + w[1] + w[2] + w[3] + 2) >>> 2;
                end else begin
                    v = w[0];
                    for (int i = 1; i < 4; i++) if (w[i] > v) v = w[i];
                end
                sb.push_back('{sel: 1, addr: r * HALF + c, data: v});
            end
        end
    endtask

    task automatic load_inputs(input int mode, input int relu);
        pool_mode = mode[0];
        relu_en   = relu[0];
        bias      = W_W'(bias_v);
        for (int t = 0; t < 9; t++) kernel[t*W_W +: W_W] = W_W'(k_v[t]);
        for (int i = 0; i < NPIX; i++) img[i] = DATA_W'(img_v[i]);
        build_expected();
    endtask

    task automatic start();
        @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
    endtask

    task automatic run_job(input int mode, input int relu);
        int cycles;
        int first_wr;
        load_inputs(mode, relu);
        start();
        check("busy_rise", longint'(busy), 1);
        cycles = 0;
        first_wr = 0;
        while (busy && cycles < BUSY_LEN + 50) begin
            cycles++;
            if (cwr && first_wr == 0) first_wr = cycles;
            ready = (cycles == 20);
            @(posedge clk);
            #1;
        end
        ready = 1'b0;
        check("busy_len", cycles, BUSY_LEN);
        check("first_cwr_cycle", first_wr, 10);
        check("sb_drained", sb.size(), 0);
        check("idle_cwr", longint'(cwr), 0);
        if (busy) begin
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
        end
        sb.delete();
    endtask

    task automatic fill_const(input int pix, input int k);
        for (int i = 0; i < NPIX; i++) img_v[i] = pix;
        for (int t = 0; t < 9; t++) k_v[t] = k;
        bias_v = 0;
    endtask

    task automatic test1_constants();
        check("t1_l0_corner", longint'(l0[0]), 64);
        check("t1_l0_edge", longint'(l0[1]), 96);
        check("t1_l0_interior", longint'(l0[5]), 144);
        check("t1_l1_first", longint'(l1[0]), 144);
        check("t1_l1_last", longint'(l1[3]), 144);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", longint'(busy), 0);
        check("rst_cwr", longint'(cwr), 0);
        check("rst_crd", longint'(crd), 0);
        check("rst_csel", longint'(csel), 0);
        check("rst_iaddr", longint'(iaddr), 0);
        check("rst_caddr_wr", longint'(caddr_wr), 0);
        check("rst_caddr_rd", longint'(caddr_rd), 0);
        check("rst_cdata_wr", longint'(cdata_wr), 0);
        reset = 1'b0;

        fill_const(16, 16);
        run_job(0, 1);
        test1_constants();

        run_job(1, 1);
        check("t2_l1_avg0", longint'(l1[0]), 100);
        check("t2_l1_avg3", longint'(l1[3]), 100);

        fill_const(4095, 16);
        run_job(0, 0);
        check("t3_sat_pos", longint'(l0[5]), 4095);
        fill_const(4095, -16);
        run_job(0, 0);
        check("t3_sat_neg", longint'(l0[0]), -4096);
        run_job(0, 1);
        check("t3_relu", longint'(l0[0]), 0);

        fill_const(1, 0);
        k_v[4] = 8;
        run_job(0, 0);
        check("t4_round_up", longint'(l0[6]), 1);
        fill_const(-1, 0);
        k_v[4] = 8;
        run_job(0, 0);
        check("t4_round_neg", longint'(l0[6]), 0);
        fill_const(0, 0);
        k_v[4] = 8;
        bias_v = 16;
        run_job(0, 0);
        check("t4_bias", longint'(l0[6]), 16);

        // Abort during pixel 5, then restart the first case from scratch.
        fill_const(16, 16);
        load_inputs(0, 1);
        begin
            int base;
            int guard;
            base = wr_count;
            guard = 0;
            start();
            while (wr_count < base + 5 && guard < 200) begin
                guard++;
                @(posedge clk);
                #1;
            end
            check("abort_reached_px5", wr_count - base, 5);
            reset = 1'b1;
            @(posedge clk);
            #1;
            check("abort_busy", longint'(busy), 0);
            check("abort_cwr", longint'(cwr), 0);
            check("abort_crd", longint'(crd), 0);
            sb.delete();
            base = wr_count;
            repeat (3) @(posedge clk);
            #1;
            check("abort_no_writes", wr_count - base, 0);
            reset = 1'b0;
        end
        for (int i = 0; i < NPIX; i++) begin
            l0[i] = 'x;
            l1[i] = 'x;
        end
        run_job(0, 1);
        test1_constants();

        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NPIX; i++)
                img_v[i] = (n % 2 == 0) ? int'($urandom_range(0, 8191)) - 4096
                                        : int'($urandom_range(0, 511)) - 256;
            for (int t = 0; t < 9; t++) k_v[t] = int'($urandom_range(0, 511)) - 256;
            bias_v = int'($urandom_range(0, 4095)) - 2048;
            run_job(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
